vc_dest_scheduler: RTL and testbench
====================================

// Module: vc_dest_scheduler
// PURPOSE
//  Schedules transfers from virtual-channel FIFOs VC0/VC1 into destination FIFOs D0/D1 (weighted round-robin, not fixed VC0 priority).
//  Issues VC pops, routes popped word by dest bit [DATA_W-2] into D0/D1 with pushes one cycle later.
//  Tracks per-destination credits so D FIFOs never overflow.
// PARAMETERS
//  DATA_W    6  word width; bit DATA_W-2 = destination id
//  D_SIZE    2  D FIFO addr width; depth DEPTH = 2**D_SIZE
//  WEIGHT_W  3  width of per-VC weight inputs
// PORTS
//  clk                  in   1         single clock, rising edge
//  reset_L              in   1         asynchronous, active-low reset
//  enable               in   1         0 = no new pops, state/credits held
//  vc0_weight_in        in   WEIGHT_W  consecutive VC0 grants per turn (0 treated as 1)
//  vc1_weight_in        in   WEIGHT_W  same for VC1
//  vc0_empty, vc1_empty in   1         VC FIFO empty flags
//  vc0_almost_empty, vc1_almost_empty  in 1  VC occupancy <= 1 (threshold 1)
//  vc0_data, vc1_data   in   DATA_W    VC FIFO data_out (valid cycle after pop)
//  pop_d0, pop_d1       in   1         consumer pops of D0/D1 (credit return)
//  pop_vc0, pop_vc1     out  1         VC pops, registered, mutually exclusive
//  push_d0, push_d1     out  1         D FIFO pushes
//  data_d0, data_d1     out  DATA_W    D FIFO write data; 0 when not pushing
//  sched_state          out  3         one-hot FSM state
//  err_out              out  1         sticky credit error
// BEHAVIOUR
//  Reset: pops/pushes/data 0, credits = DEPTH, state IDLE, last_served=VC1, grant count 0, err_out 0.
//  Eligibility elig_x: !vcx_empty & !(pop_vcx_q & vcx_almost_empty) (no pop past last word).
//  Credit gate: avail_dy = cred_dy - push_dy >= 1 for BOTH y (dest unknown at pop time).
//  Pop issued at edge t; word at t+1: push_dy = valid_q & (bit==y), data_dy = word; else 0.
//  Latency pop->push exactly 1 cycle; at most one pop per cycle, back-to-back allowed.
//  FSM one-hot: IDLE=001, SERVE_VC0=010, SERVE_VC1=100.
//   IDLE: if any elig & gate -> serve VC after last_served if eligible, else the other.
//   SERVE_VCx: pop while elig_x & gate & enable; gcnt++ per pop.
//   Turn ends when gcnt==weight_x, or !elig_x: move to other VC if eligible (gcnt=0),
//    else stay if elig_x (gcnt=0), else IDLE; last_served=x.
//   Gate low or enable low: stay in state, no pop, gcnt held.
//  Credits: cred_dy -= push_dy, += pop_dy; both same cycle -> unchanged.
//  err_out set on pop_dy with cred_dy==DEPTH, or push with cred_dy==0; counter saturates; sticky until reset.
//  Mid-operation reset clears everything asynchronously; in-flight word dropped.
// CONFIGURATION
//  SCHED_STATS_EN defined: adds outputs grant_cnt_vc0, grant_cnt_vc1 (16 b), +1 per pop, saturate at 16'hFFFF, reset 0.
//  Undefined: ports and counters absent; scheduling unchanged.
// STRUCTURE
//  Shared include sched_defs.vh: state one-hot localparams, CRED_W = D_SIZE+1.
//  Sub-module d_credit_cnt (inc, dec, count, err), instantiated for D0 and D1.
//  Top holds FSM, weight counter, pop/valid/select regs, routing demux.
// TESTING
//  Reset: reset_L=0 while popping -> next sample pops/pushes 0, credits 4, sched_state 001, err 0.
//  WRR: weights 3/1, both VCs 8 words, pop_d0/d1 always 1 -> pops VC0,VC0,VC0,VC1 repeating.
//  Routing: VC0 word 6'b001010 -> push_d0, data_d0=6'b001010 next cycle; 6'b011111 -> push_d1.
//  Backpressure: pop_d0=0, 4 words to D0 -> 4 pops then stop; one pop_d0 pulse -> one more pop.
//  Last word: VC0 one word (almost_empty=1) -> exactly one pop_vc0, then IDLE.
//  Error: pop_d1=1 with cred_d1=4 -> err_out=1, stays 1 until reset_L=0.

Source files
------------

// File: rtl/vc_dest_scheduler_pkg.sv
// Shared types for the VC-to-destination scheduler: one-hot FSM state
// encoding and VC identifiers.
package vc_dest_scheduler_pkg;

    // One-hot scheduler state, exported unchanged on sched_state.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'b001,
        ST_SERVE_VC0 = 3'b010,
        ST_SERVE_VC1 = 3'b100
    } sched_state_e;

    // VC identifiers used for last-served and select registers.
    localparam logic VC0 = 1'b0;
    localparam logic VC1 = 1'b1;

endpackage

// File: rtl/vc_dest_scheduler_d_credit_cnt.sv
// Per-destination credit counter. Starts at DEPTH (destination FIFO empty),
// decrements on every push into the destination and increments on every
// consumer pop. A pop while already at DEPTH, or a push at zero, is illegal
// and latches err until reset; the count saturates in both directions.
module vc_dest_scheduler_d_credit_cnt #(
    parameter int D_SIZE = 2
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              inc,
    input  logic              dec,
    output logic [D_SIZE:0]   count,
    output logic              err
);

    localparam int CRED_W = D_SIZE + 1;
    localparam logic [CRED_W-1:0] DEPTH = CRED_W'(2 ** D_SIZE);

    // Credit count with saturation and a sticky illegal-use flag.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            count <= DEPTH;
            err   <= 1'b0;
        end else begin
            if (inc && !dec) begin
                if (count != DEPTH) begin
                    count <= count + CRED_W'(1);
                end
            end else if (dec && !inc) begin
                if (count != '0) begin
                    count <= count - CRED_W'(1);
                end
            end
            if ((inc && (count == DEPTH)) || (dec && (count == '0))) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/vc_dest_scheduler.sv
// Weighted round-robin scheduler moving words from two virtual-channel FIFOs
// (VC0/VC1) into two destination FIFOs (D0/D1).
//
// Handshake: pop_vcX is a registered single-cycle strobe; the VC FIFO presents
// the popped word on vcX_data in the following cycle, when push_dY is asserted
// for exactly that cycle with data_dY carrying the word (destination chosen by
// word bit DATA_W-2). A pop is only issued when the VC still holds a word that
// is not already being popped and both destinations can take one more word.
//
// Optional feature macro: SCHED_STATS_EN adds 16-bit saturating grant
// counters grant_cnt_vc0 / grant_cnt_vc1.
module vc_dest_scheduler
    import vc_dest_scheduler_pkg::*;
#(
    parameter int DATA_W   = 6,
    parameter int D_SIZE   = 2,
    parameter int WEIGHT_W = 3
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic                enable,
    input  logic [WEIGHT_W-1:0] vc0_weight_in,
    input  logic [WEIGHT_W-1:0] vc1_weight_in,
    input  logic                vc0_empty,
    input  logic                vc1_empty,
    input  logic                vc0_almost_empty,
    input  logic                vc1_almost_empty,
    input  logic [DATA_W-1:0]   vc0_data,
    input  logic [DATA_W-1:0]   vc1_data,
    input  logic                pop_d0,
    input  logic                pop_d1,
    output logic                pop_vc0,
    output logic                pop_vc1,
    output logic                push_d0,
    output logic                push_d1,
    output logic [DATA_W-1:0]   data_d0,
    output logic [DATA_W-1:0]   data_d1,
    output logic [2:0]          sched_state,
    output logic                err_out
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0]         grant_cnt_vc0,
    output logic [15:0]         grant_cnt_vc1
`endif
);

    localparam int CRED_W   = D_SIZE + 1;
    localparam int DEST_BIT = DATA_W - 2;

    sched_state_e          state_q, state_d;
    logic [WEIGHT_W-1:0]   gcnt_q, gcnt_d;
    logic                  last_vc_q, last_vc_d;
    logic                  pop_vc0_q, pop_vc1_q;
    logic                  pop0_d, pop1_d;
    logic                  valid_q, sel_vc_q;

    logic                  elig0, elig1;
    logic [WEIGHT_W-1:0]   weff0, weff1;
    logic                  have_cand, cand_vc, cont_turn;
    logic                  in_flight;
    logic [DATA_W-1:0]     word;
    logic                  word_dest;
    logic [CRED_W-1:0]     cred_d0, cred_d1;
    logic [CRED_W-1:0]     need_d0, need_d1;
    logic                  credit_ok;
    logic                  err_d0, err_d1;

    // A VC is eligible if it holds a word that is not the one being popped now.
    assign elig0 = !vc0_empty && !(pop_vc0_q && vc0_almost_empty);
    assign elig1 = !vc1_empty && !(pop_vc1_q && vc1_almost_empty);

    // A weight of zero still grants one pop per turn.
    assign weff0 = (vc0_weight_in == '0) ? WEIGHT_W'(1) : vc0_weight_in;
    assign weff1 = (vc1_weight_in == '0) ? WEIGHT_W'(1) : vc1_weight_in;

    // Routing of the word popped last cycle into D0/D1.
    assign word      = (sel_vc_q == VC1) ? vc1_data : vc0_data;
    assign word_dest = word[DEST_BIT];
    assign push_d0   = valid_q && !word_dest;
    assign push_d1   = valid_q && word_dest;
    assign data_d0   = push_d0 ? word : '0;
    assign data_d1   = push_d1 ? word : '0;

    // The destination of a new pop is unknown, so both destinations must have
    // room after the push happening now and the word still in flight.
    assign in_flight = pop_vc0_q || pop_vc1_q;
    assign need_d0   = CRED_W'(push_d0) + CRED_W'(in_flight);
    assign need_d1   = CRED_W'(push_d1) + CRED_W'(in_flight);
    assign credit_ok = (cred_d0 > need_d0) && (cred_d1 > need_d1);

    assign pop_vc0     = pop_vc0_q;
    assign pop_vc1     = pop_vc1_q;
    assign sched_state = state_q;
    assign err_out     = err_d0 || err_d1;

    vc_dest_scheduler_d_credit_cnt #(.D_SIZE(D_SIZE)) u_cred_d0 (
        .clk     (clk),
        .reset_L (reset_L),
        .inc     (pop_d0),
        .dec     (push_d0),
        .count   (cred_d0),
        .err     (err_d0)
    );

    vc_dest_scheduler_d_credit_cnt #(.D_SIZE(D_SIZE)) u_cred_d1 (
        .clk     (clk),
        .reset_L (reset_L),
        .inc     (pop_d1),
        .dec     (push_d1),
        .count   (cred_d1),
        .err     (err_d1)
    );

    // Next-state logic: choose the VC to serve, then pop it if allowed.
    always_comb begin
        state_d   = state_q;
        gcnt_d    = gcnt_q;
        last_vc_d = last_vc_q;
        pop0_d    = 1'b0;
        pop1_d    = 1'b0;
        have_cand = 1'b0;
        cand_vc   = VC0;
        cont_turn = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (last_vc_q == VC1) begin
                    if (elig0) begin
                        have_cand = 1'b1;
                        cand_vc   = VC0;
                    end else if (elig1) begin
                        have_cand = 1'b1;
                        cand_vc   = VC1;
                    end
                end else begin
                    if (elig1) begin
                        have_cand = 1'b1;
                        cand_vc   = VC1;
                    end else if (elig0) begin
                        have_cand = 1'b1;
                        cand_vc   = VC0;
                    end
                end
            end
            ST_SERVE_VC0: begin
                if (elig0 && (gcnt_q < weff0)) begin
                    have_cand = 1'b1;
                    cand_vc   = VC0;
                    cont_turn = 1'b1;
                end else if (elig1) begin
                    have_cand = 1'b1;
                    cand_vc   = VC1;
                end else if (elig0) begin
                    have_cand = 1'b1;
                    cand_vc   = VC0;
                end
            end
            ST_SERVE_VC1: begin
                if (elig1 && (gcnt_q < weff1)) begin
                    have_cand = 1'b1;
                    cand_vc   = VC1;
                    cont_turn = 1'b1;
                end else if (elig0) begin
                    have_cand = 1'b1;
                    cand_vc   = VC0;
                end else if (elig1) begin
                    have_cand = 1'b1;
                    cand_vc   = VC1;
                end
            end
            default: begin
                have_cand = 1'b0;
            end
        endcase

        if (enable) begin
            if (!have_cand) begin
                state_d = ST_IDLE;
                gcnt_d  = '0;
            end else if (credit_ok) begin
                pop0_d    = (cand_vc == VC0);
                pop1_d    = (cand_vc == VC1);
                state_d   = (cand_vc == VC1) ? ST_SERVE_VC1 : ST_SERVE_VC0;
                gcnt_d    = cont_turn ? (gcnt_q + WEIGHT_W'(1)) : WEIGHT_W'(1);
                last_vc_d = cand_vc;
            end
        end
    end

    // FSM, grant counter, registered pops and the pop->push pipeline stage.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= ST_IDLE;
            gcnt_q    <= '0;
            last_vc_q <= VC1;
            pop_vc0_q <= 1'b0;
            pop_vc1_q <= 1'b0;
            valid_q   <= 1'b0;
            sel_vc_q  <= VC0;
        end else begin
            state_q   <= state_d;
            gcnt_q    <= gcnt_d;
            last_vc_q <= last_vc_d;
            pop_vc0_q <= pop0_d;
            pop_vc1_q <= pop1_d;
            valid_q   <= pop_vc0_q || pop_vc1_q;
            sel_vc_q  <= pop_vc1_q;
        end
    end

`ifdef SCHED_STATS_EN
    // Saturating per-VC grant counters, one count per issued pop.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            grant_cnt_vc0 <= '0;
            grant_cnt_vc1 <= '0;
        end else begin
            if (pop_vc0_q && (grant_cnt_vc0 != 16'hFFFF)) begin
                grant_cnt_vc0 <= grant_cnt_vc0 + 16'd1;
            end
            if (pop_vc1_q && (grant_cnt_vc1 != 16'hFFFF)) begin
                grant_cnt_vc1 <= grant_cnt_vc1 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vc_dest_scheduler.sv
// Directed testbench for vc_dest_scheduler: behavioural VC FIFOs with
// registered outputs, a destination consumer, and per-scenario tasks.
module tb_vc_dest_scheduler;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] vc0_weight_in = 3'd1;
    logic [2:0] vc1_weight_in = 3'd1;
    logic       vc0_empty, vc1_empty;
    logic       vc0_almost_empty, vc1_almost_empty;
    logic [5:0] vc0_data, vc1_data;
    logic       pop_d0, pop_d1;
    logic       pop_vc0, pop_vc1;
    logic       push_d0, push_d1;
    logic [5:0] data_d0, data_d1;
    logic [2:0] sched_state;
    logic       err_out;
`ifdef SCHED_STATS_EN
    logic [15:0] grant_cnt_vc0, grant_cnt_vc1;
`endif

    logic [5:0] q0[$];
    logic [5:0] q1[$];
    logic       pop_log[$];
    logic [6:0] push_log[$];
    logic [6:0] exp_q[$];
    int         d0_cnt, d1_cnt;
    logic       auto_consume = 1'b0;
    logic       auto_pop_d0 = 1'b0, auto_pop_d1 = 1'b0;
    logic       man_pop_d0 = 1'b0, man_pop_d1 = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;

    assign pop_d0 = auto_consume ? auto_pop_d0 : man_pop_d0;
    assign pop_d1 = auto_consume ? auto_pop_d1 : man_pop_d1;

    vc_dest_scheduler dut (
        .clk              (clk),
        .reset_L          (reset_L),
        .enable           (enable),
        .vc0_weight_in    (vc0_weight_in),
        .vc1_weight_in    (vc1_weight_in),
        .vc0_empty        (vc0_empty),
        .vc1_empty        (vc1_empty),
        .vc0_almost_empty (vc0_almost_empty),
        .vc1_almost_empty (vc1_almost_empty),
        .vc0_data         (vc0_data),
        .vc1_data         (vc1_data),
        .pop_d0           (pop_d0),
        .pop_d1           (pop_d1),
        .pop_vc0          (pop_vc0),
        .pop_vc1          (pop_vc1),
        .push_d0          (push_d0),
        .push_d1          (push_d1),
        .data_d0          (data_d0),
        .data_d1          (data_d1),
        .sched_state      (sched_state),
        .err_out          (err_out)
`ifdef SCHED_STATS_EN
        ,
        .grant_cnt_vc0    (grant_cnt_vc0),
        .grant_cnt_vc1    (grant_cnt_vc1)
`endif
    );

    // Clock.
    always #5 clk = ~clk;

    // VC FIFO models: registered data and flags, word appears after the pop.
    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            vc0_empty        <= 1'b1;
            vc1_empty        <= 1'b1;
            vc0_almost_empty <= 1'b1;
            vc1_almost_empty <= 1'b1;
            vc0_data         <= '0;
            vc1_data         <= '0;
        end else begin
            if (pop_vc0 && q0.size() > 0) vc0_data <= q0.pop_front();
            if (pop_vc1 && q1.size() > 0) vc1_data <= q1.pop_front();
            vc0_empty        <= (q0.size() == 0);
            vc1_empty        <= (q1.size() == 0);
            vc0_almost_empty <= (q0.size() <= 1);
            vc1_almost_empty <= (q1.size() <= 1);
        end
    end

    // Monitor: log pops, pushes and destination occupancy.
    always @(posedge clk) begin
        if (!reset_L) begin
            d0_cnt <= 0;
            d1_cnt <= 0;
        end else begin
            if (pop_vc0) pop_log.push_back(1'b0);
            if (pop_vc1) pop_log.push_back(1'b1);
            if (push_d0) push_log.push_back({1'b0, data_d0});
            if (push_d1) push_log.push_back({1'b1, data_d1});
            d0_cnt <= d0_cnt + int'(push_d0) - int'(pop_d0);
            d1_cnt <= d1_cnt + int'(push_d1) - int'(pop_d1);
        end
    end

    // Consumer: drain each destination whenever it holds a word.
    always @(negedge clk) begin
        auto_pop_d0 = (d0_cnt > 0);
        auto_pop_d1 = (d1_cnt > 0);
    end

    task automatic do_reset();
        reset_L    = 1'b0;
        enable     = 1'b0;
        man_pop_d0 = 1'b0;
        man_pop_d1 = 1'b0;
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clk);
        pop_log.delete();
        push_log.delete();
        reset_L = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_pops(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (pop_log.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        do_reset();
        auto_consume  = 1'b1;
        vc0_weight_in = 3'd1;
        vc1_weight_in = 3'd1;
        for (int i = 0; i < 4; i++) q0.push_back(6'h01);
        enable = 1'b1;
        wait_pops(1, 20, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL reset_pre_pop: no pop before timeout"); end
        @(posedge clk);
        #2 reset_L = 1'b0;
        @(negedge clk);
        n_checks++;
        if (pop_vc0 !== 1'b0) begin n_fail++; $display("FAIL reset_pop_vc0: got %b want 0", pop_vc0); end
        n_checks++;
        if (pop_vc1 !== 1'b0) begin n_fail++; $display("FAIL reset_pop_vc1: got %b want 0", pop_vc1); end
        n_checks++;
        if ({push_d0, push_d1} !== 2'b00) begin n_fail++; $display("FAIL reset_push: got %b want 00", {push_d0, push_d1}); end
        n_checks++;
        if ({data_d0, data_d1} !== 12'h000) begin n_fail++; $display("FAIL reset_data: got %h want 000", {data_d0, data_d1}); end
        n_checks++;
        if (sched_state !== 3'b001) begin n_fail++; $display("FAIL reset_state: got %b want 001", sched_state); end
        n_checks++;
        if (err_out !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_out); end
    endtask

    task automatic test_routing();
        bit ok;
        do_reset();
        auto_consume = 1'b1;
        enable = 1'b1;
        q0.push_back(6'b001010);
        wait_pops(1, 20, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL route0_timeout: no pop"); end
        n_checks++;
        if ({push_d0, push_d1} !== 2'b10) begin n_fail++; $display("FAIL route0_push: got %b want 10", {push_d0, push_d1}); end
        n_checks++;
        if (data_d0 !== 6'b001010) begin n_fail++; $display("FAIL route0_data_d0: got %b want 001010", data_d0); end
        n_checks++;
        if (data_d1 !== 6'b000000) begin n_fail++; $display("FAIL route0_data_d1: got %b want 000000", data_d1); end
        q0.push_back(6'b011111);
        wait_pops(2, 20, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL route1_timeout: no pop"); end
        n_checks++;
        if ({push_d0, push_d1} !== 2'b01) begin n_fail++; $display("FAIL route1_push: got %b want 01", {push_d0, push_d1}); end
        n_checks++;
        if (data_d1 !== 6'b011111) begin n_fail++; $display("FAIL route1_data_d1: got %b want 011111", data_d1); end
        n_checks++;
        if (data_d0 !== 6'b000000) begin n_fail++; $display("FAIL route1_data_d0: got %b want 000000", data_d0); end
    endtask

    task automatic test_wrr();
        bit         ok;
        logic       exp_pop[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [5:0] a[8] = '{6'h01, 6'h12, 6'h03, 6'h14, 6'h05, 6'h16, 6'h07, 6'h18};
        logic [5:0] b[8] = '{6'h21, 6'h32, 6'h23, 6'h34, 6'h25, 6'h36, 6'h27, 6'h38};
        logic [6:0] got;
        do_reset();
        auto_consume  = 1'b1;
        vc0_weight_in = 3'd3;
        vc1_weight_in = 3'd1;
        for (int i = 0; i < 8; i++) begin
            q0.push_back(a[i]);
            q1.push_back(b[i]);
        end
        // Expected pushes: A0 A1 A2 B0 A3 A4 A5 B1, lane = bit 4.
        exp_q.delete();
        exp_q.push_back({1'b0, 6'h01});
        exp_q.push_back({1'b1, 6'h12});
        exp_q.push_back({1'b0, 6'h03});
        exp_q.push_back({1'b0, 6'h21});
        exp_q.push_back({1'b1, 6'h14});
        exp_q.push_back({1'b0, 6'h05});
        exp_q.push_back({1'b1, 6'h16});
        exp_q.push_back({1'b1, 6'h32});
        enable = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (push_log.size() >= 8) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wrr_timeout: pushes %0d want 8", push_log.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (pop_log[i] !== exp_pop[i]) begin
                    n_fail++;
                    $display("FAIL wrr_pop_order[%0d]: got VC%0d want VC%0d", i, pop_log[i], exp_pop[i]);
                end
                got = push_log[i];
                n_checks++;
                if (got !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL wrr_push[%0d]: got lane %0d data %h want lane %0d data %h", i, got[6], got[5:0], exp_q[0][6], exp_q[0][5:0]);
                end
                void'(exp_q.pop_front());
            end
        end
        n_checks++;
        if (err_out !== 1'b0) begin n_fail++; $display("FAIL wrr_err: got %b want 0", err_out); end
    endtask

    task automatic test_weight_zero();
        bit   ok;
        logic exp_pop[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        do_reset();
        auto_consume  = 1'b1;
        vc0_weight_in = 3'd0;
        vc1_weight_in = 3'd2;
        for (int i = 0; i < 4; i++) q0.push_back(6'h02);
        for (int i = 0; i < 6; i++) q1.push_back(6'h13);
        enable = 1'b1;
        wait_pops(6, 300, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wzero_timeout: pops %0d want 6", pop_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (pop_log[i] !== exp_pop[i]) begin
                    n_fail++;
                    $display("FAIL wzero_pop_order[%0d]: got VC%0d want VC%0d", i, pop_log[i], exp_pop[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        auto_consume  = 1'b0;
        vc0_weight_in = 3'd1;
        vc1_weight_in = 3'd1;
        for (int i = 1; i <= 6; i++) q0.push_back(6'(i));
        enable = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++;
        if (pop_log.size() != 4) begin n_fail++; $display("FAIL bp_pops_full: got %0d want 4", pop_log.size()); end
        n_checks++;
        if (push_log.size() != 4) begin n_fail++; $display("FAIL bp_pushes_full: got %0d want 4", push_log.size()); end
        man_pop_d0 = 1'b1;
        @(negedge clk);
        man_pop_d0 = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (pop_log.size() != 5) begin n_fail++; $display("FAIL bp_pops_after_credit: got %0d want 5", pop_log.size()); end
        n_checks++;
        if (err_out !== 1'b0) begin n_fail++; $display("FAIL bp_err: got %b want 0", err_out); end
    endtask

    task automatic test_last_word();
        bit ok;
        do_reset();
        auto_consume = 1'b1;
        q0.push_back(6'h05);
        enable = 1'b1;
        wait_pops(1, 20, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL last_timeout: no pop"); end
        n_checks++;
        if (sched_state !== 3'b001) begin n_fail++; $display("FAIL last_state_after_pop: got %b want 001", sched_state); end
        n_checks++;
        if (push_d0 !== 1'b1) begin n_fail++; $display("FAIL last_push: got %b want 1", push_d0); end
        repeat (8) @(negedge clk);
        n_checks++;
        if (pop_log.size() != 1) begin n_fail++; $display("FAIL last_pop_count: got %0d want 1", pop_log.size()); end
        n_checks++;
        if (sched_state !== 3'b001) begin n_fail++; $display("FAIL last_state_idle: got %b want 001", sched_state); end
    endtask

    task automatic test_enable_hold();
        do_reset();
        auto_consume = 1'b1;
        enable = 1'b0;
        q0.push_back(6'h01);
        q0.push_back(6'h02);
        repeat (6) @(negedge clk);
        n_checks++;
        if (pop_log.size() != 0) begin n_fail++; $display("FAIL en_hold_pops: got %0d want 0", pop_log.size()); end
        n_checks++;
        if (sched_state !== 3'b001) begin n_fail++; $display("FAIL en_hold_state: got %b want 001", sched_state); end
        enable = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (pop_log.size() != 2) begin n_fail++; $display("FAIL en_resume_pops: got %0d want 2", pop_log.size()); end
    endtask

    task automatic test_error();
        do_reset();
        auto_consume = 1'b0;
        man_pop_d1 = 1'b1;
        @(negedge clk);
        man_pop_d1 = 1'b0;
        n_checks++;
        if (err_out !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", err_out); end
        repeat (5) @(negedge clk);
        n_checks++;
        if (err_out !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err_out); end
        reset_L = 1'b0;
        @(negedge clk);
        n_checks++;
        if (err_out !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b want 0", err_out); end
        reset_L = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_routing();
        test_wrr();
        test_weight_zero();
        test_backpressure();
        test_last_word();
        test_enable_hold();
        test_error();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
